// File: rtl/xepc_bank.sv
// Exception-PC bank: one xEPC per trap level, with trap capture, CSR writes and deferred capture.
// Optional macro EPC_IALIGN_EN forces bit 0 of every stored value to 0.
module xepc_bank #(
    parameter int XLEN = 64,
    parameter int NLVL = 2,
    parameter int LW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trap_valid,
    input  logic [LW-1:0]        trap_lvl,
    input  logic                 next_pc,
    input  logic [XLEN-1:0]      ins_pc,
    input  logic                 ins_c,
    input  logic                 pc_jmp,
    input  logic                 jmp_pend,
    input  logic [XLEN-1:0]      new_pc,
    input  logic                 new_pc_vld,
    input  logic                 csr_we,
    input  logic [NLVL-1:0]      csr_sel,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [NLVL*XLEN-1:0] epc_flat,
    output logic                 busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     pend_q, pend_d;
    logic [XLEN-1:0]   epc [NLVL];
    logic              trap_ok;
    logic              defer;
    logic              complete;
    logic [XLEN-1:0]   cap_val;

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] v);
`ifdef EPC_IALIGN_EN
        return v & ~XLEN'(1);
`else
        return v;
`endif
    endfunction

    // Traps are only accepted in IDLE and for an implemented level.
    assign trap_ok  = trap_valid && (state_q == IDLE) && (32'(trap_lvl) < NLVL);
    assign defer    = trap_ok && next_pc && pc_jmp && jmp_pend && !new_pc_vld;
    assign complete = (state_q == WAIT) && new_pc_vld;

    always_comb begin
        cap_val = ins_pc;
        if (next_pc) begin
            if (pc_jmp) cap_val = new_pc;
            else        cap_val = ins_pc + (ins_c ? XLEN'(2) : XLEN'(4));
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: if (defer) begin
                state_d = WAIT;
                pend_d  = trap_lvl;
            end
            WAIT: if (new_pc_vld) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Per-level priority: deferred completion, then trap capture, then CSR write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NLVL; i++) begin
            if (!rst) begin
                epc[i] <= '0;
            end else if (complete && (pend_q == LW'(i))) begin
                epc[i] <= align(new_pc);
            end else if (trap_ok && !defer && (trap_lvl == LW'(i))) begin
                epc[i] <= align(cap_val);
            end else if (csr_we && csr_sel[i] &&
                         !((state_q == WAIT) && (pend_q == LW'(i)))) begin
                epc[i] <= align(csr_wdata);
            end
        end
    end

    for (genvar g = 0; g < NLVL; g++) begin : g_flat
        assign epc_flat[g*XLEN +: XLEN] = epc[g];
    end

    assign busy = (state_q == WAIT);

endmodule

// File: tb/tb_xepc_bank.sv
// Self-checking bench for xepc_bank (XLEN=64, NLVL=3): directed steps then random traffic vs a reference model.
module tb_xepc_bank;

    localparam int XLEN = 64;
    localparam int NLVL = 3;
    localparam int LW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 trap_valid;
    logic [LW-1:0]        trap_lvl;
    logic                 next_pc;
    logic [XLEN-1:0]      ins_pc;
    logic                 ins_c;
    logic                 pc_jmp;
    logic                 jmp_pend;
    logic [XLEN-1:0]      new_pc;
    logic                 new_pc_vld;
    logic                 csr_we;
    logic [NLVL-1:0]      csr_sel;
    logic [XLEN-1:0]      csr_wdata;
    logic [NLVL*XLEN-1:0] epc_flat;
    logic                 busy;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state
    logic [XLEN-1:0] m_epc [NLVL];
    logic            m_busy;
    int              m_pend;

    xepc_bank #(.XLEN(XLEN), .NLVL(NLVL), .LW(LW)) dut (
        .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_lvl(trap_lvl),
        .next_pc(next_pc), .ins_pc(ins_pc), .ins_c(ins_c), .pc_jmp(pc_jmp),
        .jmp_pend(jmp_pend), .new_pc(new_pc), .new_pc_vld(new_pc_vld),
        .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdata(csr_wdata),
        .epc_flat(epc_flat), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] al(input logic [XLEN-1:0] v);
`ifdef EPC_IALIGN_EN
        return {v[XLEN-1:1], 1'b0};
`else
        return v;
`endif
    endfunction

    task automatic quiet();
        rst = 1'b1; trap_valid = 1'b0; trap_lvl = '0; next_pc = 1'b0;
        ins_pc = '0; ins_c = 1'b0; pc_jmp = 1'b0; jmp_pend = 1'b0;
        new_pc = '0; new_pc_vld = 1'b0; csr_we = 1'b0; csr_sel = '0; csr_wdata = '0;
    endtask

    // Applies the architectural rules to the inputs presented this cycle.
    task automatic model_step();
        logic [XLEN-1:0] nxt [NLVL];
        int lvl;
        if (!rst) begin
            for (int i = 0; i < NLVL; i++) m_epc[i] = '0;
            m_busy = 1'b0;
            m_pend = 0;
            return;
        end
        nxt = m_epc;
        lvl = int'(trap_lvl);
        for (int i = 0; i < NLVL; i++)
            if (csr_we && csr_sel[i] && !(m_busy && m_pend == i)) nxt[i] = al(csr_wdata);
        if (m_busy) begin
            if (new_pc_vld) begin
                nxt[m_pend] = al(new_pc);
                m_busy = 1'b0;
            end
        end else if (trap_valid && lvl < NLVL) begin
            if (!next_pc)                     nxt[lvl] = al(ins_pc);
            else if (!pc_jmp)                 nxt[lvl] = al(ins_pc + (ins_c ? 64'd2 : 64'd4));
            else if (!jmp_pend || new_pc_vld) nxt[lvl] = al(new_pc);
            else begin
                m_busy = 1'b1;
                m_pend = lvl;
            end
        end
        m_epc = nxt;
    endtask

    task automatic check_val(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NLVL; i++)
            check_val($sformatf("%s epc[%0d]", tag, i), epc_flat[i*XLEN +: XLEN], m_epc[i]);
        check_val($sformatf("%s busy", tag), {63'd0, busy}, {63'd0, m_busy});
    endtask

    // Inputs are set after a negedge; the model advances, the edge fires, outputs are sampled 1 ns later.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NLVL; i++) m_epc[i] = '1;
        m_busy = 1'b0;
        m_pend = 0;
        quiet();
        @(negedge clk);

        // reset wins over trap and CSR write
        rst = 1'b0; trap_valid = 1'b1; csr_we = 1'b1; csr_sel = '1; csr_wdata = 64'hAAAA;
        ins_pc = 64'h55;
        cycle("reset1");
        cycle("reset2");
        check_val("reset epc0 zero", epc_flat[0 +: XLEN], 64'd0);
        check_val("reset busy zero", {63'd0, busy}, 64'd0);

        // capture of ins_pc
        quiet(); trap_valid = 1'b1; trap_lvl = 2'd1; ins_pc = 64'h8000_0010;
        cycle("cap_ins_pc");
        check_val("cap_ins_pc const", epc_flat[XLEN +: XLEN], 64'h8000_0010);
        check_val("cap_ins_pc lvl0 kept", epc_flat[0 +: XLEN], 64'd0);

        // compressed step wraps
        quiet(); trap_valid = 1'b1; trap_lvl = 2'd0; next_pc = 1'b1; ins_c = 1'b1;
        ins_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        cycle("cap_wrap");
        check_val("cap_wrap const", epc_flat[0 +: XLEN], 64'd0);

        // 32-bit step
        quiet(); trap_valid = 1'b1; trap_lvl = 2'd2; next_pc = 1'b1; ins_pc = 64'h1000;
        cycle("cap_plus4");
        check_val("cap_plus4 const", epc_flat[2*XLEN +: XLEN], 64'h1004);

        // deferred capture with CSR writes during WAIT
        quiet(); trap_valid = 1'b1; trap_lvl = 2'd0; next_pc = 1'b1; pc_jmp = 1'b1; jmp_pend = 1'b1;
        cycle("defer_start");
        check_val("defer busy up", {63'd0, busy}, 64'd1);
        quiet(); csr_we = 1'b1; csr_sel = 3'b001; csr_wdata = 64'hDEAD;
        cycle("wait_csr_pend");
        check_val("wait_csr_pend dropped", epc_flat[0 +: XLEN], 64'd0);
        quiet(); csr_we = 1'b1; csr_sel = 3'b010; csr_wdata = 64'h5554;
        cycle("wait_csr_other");
        check_val("wait_csr_other lands", epc_flat[XLEN +: XLEN], 64'h5554);
        quiet(); new_pc = 64'h1234; new_pc_vld = 1'b1; csr_we = 1'b1; csr_sel = 3'b001; csr_wdata = 64'h77;
        cycle("defer_done");
        check_val("defer_done value", epc_flat[0 +: XLEN], 64'h1234);
        check_val("defer_done busy", {63'd0, busy}, 64'd0);

        // trap vs CSR collision
        quiet(); trap_valid = 1'b1; trap_lvl = 2'd1; ins_pc = 64'h40;
        csr_we = 1'b1; csr_sel = 3'b011; csr_wdata = 64'h99;
        cycle("collision");
        check_val("collision trap wins", epc_flat[XLEN +: XLEN], 64'h40);
        check_val("collision csr other", epc_flat[0 +: XLEN], al(64'h99));

        // illegal level
        quiet(); trap_valid = 1'b1; trap_lvl = 2'd3; next_pc = 1'b1; pc_jmp = 1'b1; jmp_pend = 1'b1;
        ins_pc = 64'hBAD0;
        cycle("illegal_lvl");
        check_val("illegal_lvl busy", {63'd0, busy}, 64'd0);

        // alignment of CSR data
        quiet(); csr_we = 1'b1; csr_sel = 3'b100; csr_wdata = 64'h1003;
        cycle("csr_align");
`ifdef EPC_IALIGN_EN
        check_val("csr_align const", epc_flat[2*XLEN +: XLEN], 64'h1002);
`else
        check_val("csr_align const", epc_flat[2*XLEN +: XLEN], 64'h1003);
`endif

        // reset during WAIT aborts the capture
        quiet(); trap_valid = 1'b1; trap_lvl = 2'd2; next_pc = 1'b1; pc_jmp = 1'b1; jmp_pend = 1'b1;
        cycle("abort_defer");
        quiet(); rst = 1'b0; new_pc = 64'hF00; new_pc_vld = 1'b1;
        cycle("abort_reset");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            quiet();
            rst        = ($urandom_range(0, 49) != 0);
            trap_valid = ($urandom_range(0, 2) == 0);
            trap_lvl   = LW'($urandom_range(0, 3));
            next_pc    = $urandom_range(0, 1) == 1;
            ins_c      = $urandom_range(0, 1) == 1;
            pc_jmp     = $urandom_range(0, 1) == 1;
            jmp_pend   = $urandom_range(0, 1) == 1;
            new_pc_vld = ($urandom_range(0, 3) == 0);
            ins_pc     = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) ins_pc = 64'hFFFF_FFFF_FFFF_FFFC | 64'($urandom_range(0, 3));
            new_pc     = {$urandom(), $urandom()};
            csr_we     = ($urandom_range(0, 2) == 0);
            csr_sel    = NLVL'($urandom_range(0, 7));
            csr_wdata  = {$urandom(), $urandom()};
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
